// File: rtl/poly_shape_interp_pkg.sv
// shape_pkg: shared constants, symbol encodings and helper functions for the
// polyphase pulse-shaping interpolator.
//   clog2     - ceiling log2, used for counter/index widths
//   saturate  - clamps a 64-bit signed value to a w-bit signed range
package shape_pkg;

    localparam int DEF_NUM_CH    = 2;
    localparam int DEF_DATA_W    = 2;
    localparam int DEF_COEF_W    = 16;
    localparam int DEF_OUT_W     = 24;
    localparam int DEF_SPS       = 8;
    localparam int DEF_SPAN      = 6;
    localparam int DEF_OUT_SHIFT = 0;

    localparam logic [1:0] SYM_POS = 2'b01;
    localparam logic [1:0] SYM_NEG = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // When the value already fits in w bits this is an identity, so the same
    // call covers both the sign-extend and the clamp case.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/poly_shape_interp_tap_sum.sv
// shape_tap_sum: combinational dot product for one channel.
//   phase - polyphase index p; selects taps coef[k*SPS + p]
//   coef  - full coefficient bank (NT entries)
//   taps  - this channel's delay line, dl[0..SPAN-1]
//   sum   - full-precision signed sum, FW bits
module shape_tap_sum
    import shape_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int SPS    = DEF_SPS,
    parameter int SPAN   = DEF_SPAN,
    parameter int NT     = SPS * SPAN,
    parameter int PW     = (clog2(SPS) > 0) ? clog2(SPS) : 1,
    parameter int AW     = (clog2(NT) > 0) ? clog2(NT) : 1,
    parameter int FW     = DATA_W + COEF_W + clog2(SPAN)
) (
    input  logic [PW-1:0]                 phase,
    input  logic [NT-1:0][COEF_W-1:0]     coef,
    input  logic [SPAN-1:0][DATA_W-1:0]   taps,
    output logic signed [FW-1:0]          sum
);

    logic [AW-1:0]                      idx;
    logic signed [DATA_W-1:0]           d;
    logic signed [COEF_W-1:0]           cf;
    logic signed [DATA_W+COEF_W-1:0]    prod;
    logic signed [FW-1:0]               term;
    logic signed [FW-1:0]               acc;

    always_comb begin
        idx  = '0;
        d    = '0;
        cf   = '0;
        prod = '0;
        term = '0;
        acc  = '0;
        for (int k = 0; k < SPAN; k++) begin
            idx  = AW'(k * SPS) + AW'(phase);
            d    = taps[k];
            cf   = coef[idx];
            prod = d * cf;
            term = FW'(prod);
            acc  = acc + term;
        end
        sum = acc;
    end

endmodule

// File: rtl/poly_shape_interp.sv
// poly_shape_interp: polyphase pulse-shaping interpolator.
// Takes one signed symbol per channel per symbol period and emits SPS shaped
// samples per symbol on a ready/valid stream. After the last real symbol the
// filter keeps running on zeros until the delay line is empty (SPAN missing
// symbols), then returns to IDLE.
//   clk_dds, rst       - clock, synchronous active-high reset
//   s_axis_*           - symbol input, channel c at [c*DATA_W +: DATA_W]
//   m_axis_*           - sample output, channel c at [c*OUT_W +: OUT_W];
//                        tuser carries the polyphase index
//   coef_we/addr/data  - runtime coefficient write port
//   starved            - sticky: a symbol was missing while not draining
module poly_shape_interp
    import shape_pkg::*;
#(
    parameter int NUM_CH    = DEF_NUM_CH,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int COEF_W    = DEF_COEF_W,
    parameter int OUT_W     = DEF_OUT_W,
    parameter int SPS       = DEF_SPS,
    parameter int SPAN      = DEF_SPAN,
    parameter int OUT_SHIFT = DEF_OUT_SHIFT,
    localparam int NT = SPS * SPAN,
    localparam int PW = (clog2(SPS) > 0) ? clog2(SPS) : 1,
    localparam int AW = (clog2(NT) > 0) ? clog2(NT) : 1
) (
    input  logic                      clk_dds,
    input  logic                      rst,
    input  logic [NUM_CH*DATA_W-1:0]  s_axis_tdata,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [NUM_CH*OUT_W-1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [PW-1:0]             m_axis_tuser,
    input  logic                      coef_we,
    input  logic [AW-1:0]             coef_addr,
    input  logic [COEF_W-1:0]         coef_data,
    output logic                      starved
);

    localparam int ZW      = clog2(SPAN + 1);
    localparam int FW      = DATA_W + COEF_W + clog2(SPAN);
    localparam int IMP_TAP = (SPAN / 2) * SPS;
    localparam logic [COEF_W-1:0] COEF_ONE = {2'b01, {(COEF_W-2){1'b0}}};

    state_t state, state_nxt;

    logic [NUM_CH-1:0][SPAN-1:0][DATA_W-1:0] dl;
    logic [NUM_CH-1:0][DATA_W-1:0]           sym;
    logic [NT-1:0][COEF_W-1:0]               coef;
    logic [NUM_CH-1:0][OUT_W-1:0]            samp;
    logic [NUM_CH-1:0][OUT_W-1:0]            tdata_r;
    logic [PW-1:0]                           p;
    logic [ZW-1:0]                           zr;

    logic adv;
    logic last_ph;
    logic bound;

    assign sym          = s_axis_tdata;
    assign m_axis_tdata = tdata_r;

    // Output register is free to take a new sample this cycle.
    assign adv     = !m_axis_tvalid || m_axis_tready;
    assign last_ph = (p == PW'(SPS - 1));
    assign bound   = (state == ST_RUN) && adv && last_ph;

    // Per-channel dot product and output scaling.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [FW-1:0] sum;
        logic signed [63:0]   wide;

        shape_tap_sum #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .SPS    (SPS),
            .SPAN   (SPAN),
            .NT     (NT),
            .PW     (PW),
            .AW     (AW),
            .FW     (FW)
        ) u_sum (
            .phase (p),
            .coef  (coef),
            .taps  (dl[c]),
            .sum   (sum)
        );

        assign wide    = 64'(sum);
        assign samp[c] = OUT_W'(saturate(wide >>> OUT_SHIFT, OUT_W));
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_dds) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (s_axis_tvalid) state_nxt = ST_RUN;
            // SPAN-th consecutive missing symbol empties the delay line.
            ST_RUN:  if (bound && !s_axis_tvalid && zr == ZW'(SPAN - 1))
                         state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // In RUN a symbol is only taken together with its delay-line shift.
    always_comb begin
        s_axis_tready = 1'b0;
        case (state)
            ST_IDLE: s_axis_tready = 1'b1;
            ST_RUN:  s_axis_tready = adv && last_ph;
            default: s_axis_tready = 1'b0;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk_dds) begin
        if (rst) begin
            p             <= '0;
            zr            <= '0;
            dl            <= '0;
            tdata_r       <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= '0;
            starved       <= 1'b0;
            for (int i = 0; i < NT; i++)
                coef[i] <= (i == IMP_TAP) ? COEF_ONE : '0;
        end else begin
            if (coef_we && (32'(coef_addr) < NT))
                coef[coef_addr] <= coef_data;

            case (state)
                ST_IDLE: begin
                    if (m_axis_tvalid && m_axis_tready)
                        m_axis_tvalid <= 1'b0;
                    if (s_axis_tvalid) begin
                        dl <= '0;
                        for (int c = 0; c < NUM_CH; c++)
                            dl[c][0] <= sym[c];
                        p  <= '0;
                        zr <= '0;
                    end
                end
                ST_RUN: begin
                    if (adv) begin
                        tdata_r       <= samp;
                        m_axis_tuser  <= p;
                        m_axis_tvalid <= 1'b1;
                        if (!last_ph) begin
                            p <= p + PW'(1);
                        end else begin
                            p <= '0;
                            for (int c = 0; c < NUM_CH; c++)
                                for (int k = 1; k < SPAN; k++)
                                    dl[c][k] <= dl[c][k-1];
                            if (s_axis_tvalid) begin
                                for (int c = 0; c < NUM_CH; c++)
                                    dl[c][0] <= sym[c];
                                zr <= '0;
                            end else begin
                                for (int c = 0; c < NUM_CH; c++)
                                    dl[c][0] <= '0;
                                zr <= zr + ZW'(1);
                                // Only the first gap after real data is a starvation;
                                // later gaps are the intentional drain.
                                if (zr == '0) starved <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_shape_interp.sv
module tb_poly_shape_interp;
    import shape_pkg::*;

    logic        clk_dds = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [47:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [2:0]  m_axis_tuser;
    logic        coef_we = 1'b0;
    logic [5:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        starved;

    logic [15:0] d8_tdata;
    logic        d8_tvalid, d8_sready, d8_starved;
    logic [2:0]  d8_tuser;

    logic signed [23:0] o_i, o_q;
    logic signed [7:0]  e_i, e_q;
    assign o_i = m_axis_tdata[23:0];
    assign o_q = m_axis_tdata[47:24];
    assign e_i = d8_tdata[7:0];
    assign e_q = d8_tdata[15:8];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk_dds = ~clk_dds;

    poly_shape_interp dut (
        .clk_dds(clk_dds), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .starved(starved)
    );

    poly_shape_interp #(.OUT_W(8)) dut8 (
        .clk_dds(clk_dds), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(d8_sready),
        .m_axis_tdata(d8_tdata), .m_axis_tvalid(d8_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(d8_tuser),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .starved(d8_starved)
    );

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_dds);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        coef_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_all(input logic [15:0] v);
        for (int i = 0; i < 48; i++) begin
            coef_we   = 1'b1;
            coef_addr = 6'(i);
            coef_data = v;
            tick();
        end
        coef_we = 1'b0;
    endtask

    function automatic longint fill(input int j);
        return longint'((j / 8 + 1 > 6) ? 6 : j / 8 + 1);
    endfunction

    // One +1 on I / -1 on Q, then drain with default impulse taps.
    task automatic run_impulse(input string tag);
        int n;
        n = 0;
        s_axis_tdata  = {SYM_NEG, SYM_POS};
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (!m_axis_tvalid) break;
            chk({tag, "_user"}, longint'(m_axis_tuser), longint'(n % 8));
            chk({tag, "_i"}, longint'(o_i), (n == 24) ? 64'sd16384 : 64'sd0);
            chk({tag, "_q"}, longint'(o_q), (n == 24) ? -64'sd16384 : 64'sd0);
            n++;
        end
        chk({tag, "_count"}, longint'(n), 48);
        chk({tag, "_starved"}, longint'(starved), 1);
        chk({tag, "_idle_rdy"}, longint'(s_axis_tready), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1);
    end

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_tvalid", longint'(m_axis_tvalid), 0);
        chk("rst_tdata", longint'(m_axis_tdata), 0);
        chk("rst_tuser", longint'(m_axis_tuser), 0);
        chk("rst_starved", longint'(starved), 0);
        chk("rst_sready", longint'(s_axis_tready), 1);

        // ---- impulse drain ----
        run_impulse("imp");

        // ---- backpressure on a continuous stream ----
        s_axis_tdata  = {SYM_NEG, SYM_POS};
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        for (int j = 0; j <= 30; j++) begin
            tick();
            chk("bp_user", longint'(m_axis_tuser), longint'(j % 8));
            chk("bp_i", longint'(o_i), (j % 8 == 0 && j >= 24) ? 64'sd16384 : 64'sd0);
            chk("bp_q", longint'(o_q), (j % 8 == 0 && j >= 24) ? -64'sd16384 : 64'sd0);
        end
        chk("bp_sready_pre", longint'(s_axis_tready), 1);
        m_axis_tready = 1'b0;
        #1;
        chk("bp_sready_stall", longint'(s_axis_tready), 0);
        repeat (5) begin
            tick();
            chk("bp_hold_vld", longint'(m_axis_tvalid), 1);
            chk("bp_hold_user", longint'(m_axis_tuser), 6);
            chk("bp_hold_i", longint'(o_i), 0);
            chk("bp_hold_sready", longint'(s_axis_tready), 0);
        end
        m_axis_tready = 1'b1;
        tick();
        chk("bp_rel_user7", longint'(m_axis_tuser), 7);
        chk("bp_rel_i7", longint'(o_i), 0);
        tick();
        chk("bp_rel_user0", longint'(m_axis_tuser), 0);
        chk("bp_rel_i0", longint'(o_i), 16384);
        chk("bp_rel_q0", longint'(o_q), -16384);

        // ---- all taps = 1, continuous +1, invalid write mid-run ----
        do_reset();
        load_all(16'd1);
        s_axis_tdata  = {SYM_POS, SYM_POS};
        s_axis_tvalid = 1'b1;
        tick();
        for (int j = 0; j < 64; j++) begin
            if (j == 30) begin
                coef_we   = 1'b1;
                coef_addr = 6'd48;
                coef_data = 16'h7fff;
            end
            tick();
            coef_we = 1'b0;
            chk("ones_i", longint'(o_i), fill(j));
            chk("ones_q", longint'(o_q), fill(j));
        end
        chk("ones_starved", longint'(starved), 0);
        s_axis_tvalid = 1'b0;
        for (int t = 0; t < 200; t++) begin
            tick();
            if (!m_axis_tvalid) break;
        end
        chk("ones_drained", longint'(m_axis_tvalid), 0);
        chk("ones_starved_end", longint'(starved), 1);

        // ---- reset in the middle of a symbol ----
        s_axis_tdata  = {SYM_POS, SYM_POS};
        s_axis_tvalid = 1'b1;
        tick();
        repeat (3) tick();
        chk("mr_pre_i", longint'(o_i), 1);
        rst = 1'b1;
        tick();
        chk("mr_tvalid", longint'(m_axis_tvalid), 0);
        chk("mr_tdata", longint'(m_axis_tdata), 0);
        chk("mr_sready", longint'(s_axis_tready), 1);
        chk("mr_starved", longint'(starved), 0);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        run_impulse("mr_imp");

        // ---- saturation: taps 32767, OUT_W=8 instance clamps ----
        do_reset();
        load_all(16'h7fff);
        s_axis_tdata  = {SYM_POS, SYM_POS};
        s_axis_tvalid = 1'b1;
        tick();
        for (int j = 0; j < 48; j++) begin
            tick();
            chk("satp_wide", longint'(o_i), fill(j) * 32767);
            chk("satp_i8", longint'(e_i), 127);
            chk("satp_q8", longint'(e_q), 127);
        end
        do_reset();
        load_all(16'h7fff);
        s_axis_tdata  = {SYM_NEG, SYM_NEG};
        s_axis_tvalid = 1'b1;
        tick();
        for (int j = 0; j < 48; j++) begin
            tick();
            chk("satn_wide", longint'(o_q), -fill(j) * 32767);
            chk("satn_i8", longint'(e_i), -128);
            chk("satn_q8", longint'(e_q), -128);
        end
        s_axis_tvalid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
